cache_controller: RTL and testbench

Direct-mapped, write-through, write-around (no write-allocate) data cache between the RISC core's load/store port and `data_memory`. It holds 32 lines of 128 bits (four 32-bit words each) with per-line valid and tag. Read hits return data in the same cycle. Read misses fetch a full line from `data_memory`. All writes go through to memory; a write that hits also updates the cached word. The core is stalled for the duration of every memory transaction.

---
 rtl/cache_controller.sv | 150 +++++++++++++++
 tb/tb_cache_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped, write-through, write-around data cache controller
module cache_controller #(
  parameter int RISC_data   = 32,
  parameter int main_data   = 128,
  parameter int cache_depth = 32,
  parameter int addr_width  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_RE,
  input  logic                  cpu_WE,
  input  logic [addr_width-1:0] cpu_addr,
  input  logic [RISC_data-1:0]  cpu_WD,
  output logic [RISC_data-1:0]  cpu_RD,
  output logic                  stall,
  output logic                  mem_RE,
  output logic                  mem_WE,
  output logic [addr_width-3:0] mem_addr,
  output logic [1:0]            mem_word_loc,
  output logic [RISC_data-1:0]  mem_WD,
  input  logic [main_data-1:0]  mem_RD,
  input  logic                  mem_done
);

  localparam int idx_w = $clog2(cache_depth);
  localparam int tag_w = addr_width - 2 - idx_w;
  localparam int lsb_w = $clog2(main_data);

  typedef enum logic [2:0] {
    DRAIN = 3'd0,
    IDLE  = 3'd1,
    RMISS = 3'd2,
    FILL  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t state, state_nx;
  logic [2:0] drain_cnt;

  logic [main_data-1:0] line_data [cache_depth];
  logic [tag_w-1:0]     line_tag  [cache_depth];
  logic [cache_depth-1:0] line_valid;

  logic [idx_w-1:0] idx;
  logic [tag_w-1:0] tag_in;
  logic [1:0]       word;
  logic [lsb_w-1:0] word_lsb;
  logic             hit;
  logic [RISC_data-1:0] cached_word;
  logic [RISC_data-1:0] fill_word;
  logic             fill_en;
  logic             wr_hit_en;

  assign idx      = cpu_addr[idx_w+1:2];
  assign tag_in   = cpu_addr[addr_width-1:idx_w+2];
  assign word     = cpu_addr[1:0];
  assign word_lsb = lsb_w'(word) << $clog2(RISC_data);

  assign hit         = line_valid[idx] && (line_tag[idx] == tag_in);
  assign cached_word = line_data[idx][word_lsb +: RISC_data];
  assign fill_word   = mem_RD[word_lsb +: RISC_data];

  // The core holds its request for the whole transaction, so these track it directly.
  assign mem_addr     = cpu_addr[addr_width-1:2];
  assign mem_word_loc = word;
  assign mem_WD       = cpu_WD;

  // Strobes follow the next state, so they drop on the same edge that sees mem_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DRAIN;
      drain_cnt <= 3'd0;
      mem_RE    <= 1'b0;
      mem_WE    <= 1'b0;
    end else begin
      state     <= state_nx;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      mem_RE    <= (state_nx == RMISS);
      mem_WE    <= (state_nx == WRITE);
    end
  end

  always_comb begin
    state_nx  = state;
    stall     = 1'b0;
    cpu_RD    = '0;
    fill_en   = 1'b0;
    wr_hit_en = 1'b0;
    case (state)
      DRAIN: begin
        stall = 1'b1;
        if (drain_cnt == 3'd4) state_nx = IDLE;
      end
      IDLE: begin
        if (cpu_WE) begin
          stall    = 1'b1;
          state_nx = WRITE;
        end else if (cpu_RE) begin
          if (hit) begin
            cpu_RD = cached_word;
          end else begin
            stall    = 1'b1;
            state_nx = RMISS;
          end
        end
      end
      RMISS: begin
        stall = 1'b1;
        if (mem_done) state_nx = FILL;
      end
      FILL: begin
        cpu_RD   = fill_word;
        fill_en  = 1'b1;
        state_nx = IDLE;
      end
      WRITE: begin
        stall = !mem_done;
        if (mem_done) begin
          wr_hit_en = hit;
          state_nx  = IDLE;
        end
      end
      default: begin
        stall    = 1'b1;
        state_nx = DRAIN;
      end
    endcase
  end

  // Tag and data storage carry no reset; only the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_en) begin
        line_data[idx] <= mem_RD;
        line_tag[idx]  <= tag_in;
      end else if (wr_hit_en) begin
        line_data[idx][word_lsb +: RISC_data] <= cpu_WD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid <= '0;
    end else if (fill_en) begin
      line_valid[idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed bench for cache_controller with a 5-cycle memory model
module tb_cache_controller;

  logic         clk;
  logic         rst;
  logic         cpu_RE;
  logic         cpu_WE;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_WD;
  logic [31:0]  cpu_RD;
  logic         stall;
  logic         mem_RE;
  logic         mem_WE;
  logic [7:0]   mem_addr;
  logic [1:0]   mem_word_loc;
  logic [31:0]  mem_WD;
  logic [127:0] mem_RD;
  logic         mem_done;

  logic [127:0] mem_lines [256];
  int n_tests;
  int n_fail;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_RE       (cpu_RE),
    .cpu_WE       (cpu_WE),
    .cpu_addr     (cpu_addr),
    .cpu_WD       (cpu_WD),
    .cpu_RD       (cpu_RD),
    .stall        (stall),
    .mem_RE       (mem_RE),
    .mem_WE       (mem_WE),
    .mem_addr     (mem_addr),
    .mem_word_loc (mem_word_loc),
    .mem_WD       (mem_WD),
    .mem_RD       (mem_RD),
    .mem_done     (mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input int line, input int k);
    return 32'hA500_0000 | 32'(line << 8) | 32'(k);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory: strobe seen in cycles 1..5 of a transaction, mem_done raised in cycle 5.
  int mem_cnt;
  initial begin
    mem_done = 1'b0;
    mem_RD   = '0;
    mem_cnt  = 0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_RE || mem_WE) begin
        mem_cnt++;
        if (mem_cnt == 5) begin
          mem_done = 1'b1;
          if (mem_RE) mem_RD = mem_lines[mem_addr];
          else mem_lines[mem_addr][{mem_word_loc, 5'b0} +: 32] = mem_WD;
        end else begin
          mem_done = 1'b0;
        end
      end else begin
        mem_cnt  = 0;
        mem_done = 1'b0;
      end
    end
  end

  task automatic count_drain(input string tag);
    int n;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      @(posedge clk);
      #1;
    end
    check({tag, " drain stalls"}, 32'(n), 32'd5);
    check({tag, " idle rd"}, cpu_RD, 32'd0);
    check({tag, " idle strobes"}, {30'd0, mem_RE, mem_WE}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic read_op(input logic [9:0] addr, input logic [31:0] exp_data,
                         input int exp_stalls, input string tag);
    int stalls, re_n, we_n;
    logic got;
    stalls = 0; re_n = 0; we_n = 0; got = 1'b0;
    cpu_addr = addr; cpu_RE = 1'b1; cpu_WE = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_RE) re_n++;
      if (mem_WE) we_n++;
      if (!stall) begin
        got = 1'b1;
        check({tag, " data"}, cpu_RD, exp_data);
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    cpu_RE = 1'b0;
    check({tag, " completed"}, 32'(got), 32'd1);
    check({tag, " stalls"}, 32'(stalls), 32'(exp_stalls));
    check({tag, " re cycles"}, 32'(re_n), (exp_stalls != 0) ? 32'd5 : 32'd0);
    check({tag, " we cycles"}, 32'(we_n), 32'd0);
  endtask

  task automatic write_op(input logic [9:0] addr, input logic [31:0] data,
                          input logic also_re, input string tag);
    int stalls, re_n, we_n;
    logic got;
    logic [1:0] loc;
    logic [7:0] la;
    stalls = 0; re_n = 0; we_n = 0; got = 1'b0; loc = 2'd0; la = 8'd0;
    cpu_addr = addr; cpu_WD = data; cpu_WE = 1'b1; cpu_RE = also_re;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_RE) re_n++;
      if (mem_WE) begin
        we_n++;
        loc = mem_word_loc;
        la  = mem_addr;
      end
      if (!stall) begin
        got = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    cpu_WE = 1'b0;
    cpu_RE = 1'b0;
    check({tag, " completed"}, 32'(got), 32'd1);
    check({tag, " stalls"}, 32'(stalls), 32'd5);
    check({tag, " we cycles"}, 32'(we_n), 32'd5);
    check({tag, " re cycles"}, 32'(re_n), 32'd0);
    check({tag, " word loc"}, 32'(loc), 32'(addr[1:0]));
    check({tag, " line addr"}, 32'(la), 32'(addr[9:2]));
  endtask

  initial begin
    int n;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < 4; k++)
        mem_lines[i][k*32 +: 32] = word_of(i, k);
    rst = 1'b1; cpu_RE = 1'b0; cpu_WE = 1'b0; cpu_addr = '0; cpu_WD = '0;

    @(posedge clk);
    @(negedge clk);
    check("reset stall", 32'(stall), 32'd1);
    check("reset strobes", {30'd0, mem_RE, mem_WE}, 32'd0);
    check("reset rd", cpu_RD, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    count_drain("t1");

    read_op(10'h004, word_of(1, 0), 6, "t1 miss 004");
    read_op(10'h005, word_of(1, 1), 0, "t2 hit 005");

    read_op(10'h084, word_of(8'h21, 0), 6, "t3 miss 084");
    read_op(10'h004, word_of(1, 0), 6, "t3 evicted 004");

    write_op(10'h006, 32'hDEADBEEF, 1'b0, "t4 write hit");
    read_op(10'h006, 32'hDEADBEEF, 0, "t4 read 006");
    write_op(10'h3F0, 32'hCAFEF00D, 1'b0, "t4 write miss");
    read_op(10'h3F0, 32'hCAFEF00D, 6, "t4 read 3f0");

    write_op(10'h005, 32'h12345678, 1'b1, "t5 re+we");
    read_op(10'h005, 32'h12345678, 0, "t5 read 005");
    read_op(10'h004, word_of(1, 0), 0, "t5 read 004");

    cpu_addr = 10'h0A8; cpu_RE = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6 re before reset", 32'(mem_RE), 32'd1);
    rst = 1'b1;
    cpu_RE = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6 re after reset", 32'(mem_RE), 32'd0);
    check("t6 stall after reset", 32'(stall), 32'd1);
    n = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    check("t6 drain stalls", 32'(n), 32'd5);
    @(posedge clk);
    #1;
    read_op(10'h005, 32'h12345678, 6, "t6 miss 005");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
